// File: rtl/march_bist_ctrl_if.sv
// Bundle of the BIST handshake, SRAM port and first-failure diagnostics.
// The controller takes the master side; the SRAM wrapper / test controller take the slave side.
interface march_bist_ctrl_if #(
   parameter int ADDR_W = 4,
   parameter int DATA_W = 32,
   parameter int CNT_W  = 16
);
   logic              bist_start;
   logic              bist_busy;
   logic              bist_done;
   logic              bist_fail;
   logic              mem_en;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;
   logic [ADDR_W-1:0] fail_addr;
   logic [1:0]        fail_bg;
   logic [2:0]        fail_elem;
   logic [DATA_W-1:0] fail_expected;
   logic [DATA_W-1:0] fail_actual;
   logic [CNT_W-1:0]  fail_count;

   modport master (
      input  bist_start, mem_rdata,
      output bist_busy, bist_done, bist_fail, mem_en, mem_we, mem_addr, mem_wdata,
             fail_addr, fail_bg, fail_elem, fail_expected, fail_actual, fail_count
   );

   modport slave (
      output bist_start, mem_rdata,
      input  bist_busy, bist_done, bist_fail, mem_en, mem_we, mem_addr, mem_wdata,
             fail_addr, fail_bg, fail_elem, fail_expected, fail_actual, fail_count
   );
endinterface

// File: rtl/march_bist_ctrl.sv
// March C- BIST controller for a single-port SRAM with 1-cycle read latency.
// One SRAM op per cycle; reads are compared one cycle later and the first failure is captured.
module march_bist_ctrl #(
   parameter int ADDR_W       = 4,
   parameter int DATA_W       = 32,
   parameter int NUM_BG       = 4,
   parameter int CNT_W        = 16,
   parameter bit STOP_ON_FAIL = 1'b0
) (
   input  logic              clk,
   input  logic              rst,
   march_bist_ctrl_if.master bus
);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_e;

   localparam logic [1:0] LAST_BG = 2'(NUM_BG - 1);

   state_e            state_q, state_d;
   logic [1:0]        bg_q, bg_d;
   logic [2:0]        elem_q, elem_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              phase_q, phase_d;
   logic              drain_q, drain_d;

   logic              rd_vld_q;
   logic [DATA_W-1:0] exp_q;
   logic [ADDR_W-1:0] cmp_addr_q;
   logic [1:0]        cmp_bg_q;
   logic [2:0]        cmp_elem_q;

   logic              fail_q;
   logic [ADDR_W-1:0] fail_addr_q;
   logic [1:0]        fail_bg_q;
   logic [2:0]        fail_elem_q;
   logic [DATA_W-1:0] fail_exp_q;
   logic [DATA_W-1:0] fail_act_q;
   logic [CNT_W-1:0]  fail_count_q;

   logic              run, start_ok, two_op, is_read, invert, down;
   logic              last_in_addr, elem_end, mismatch;
   logic [ADDR_W-1:0] op_addr;
   logic [DATA_W-1:0] op_data;

   function automatic logic [DATA_W-1:0] bg_pattern(input logic [1:0] bg);
      logic [7:0] b;
      case (bg)
         2'd0:    b = 8'h00;
         2'd1:    b = 8'h55;
         2'd2:    b = 8'h33;
         default: b = 8'h0F;
      endcase
      return {(DATA_W/8){b}};
   endfunction

   // Op decode: phase 0 is the read of a two-op element, phase 1 its write.
   // Descending elements count addr_q upward and drive its complement.
   always_comb begin
      run          = (state_q == S_RUN);
      start_ok     = bus.bist_start && ((state_q == S_IDLE) || (state_q == S_DONE));
      two_op       = (elem_q != 3'd0) && (elem_q != 3'd5);
      is_read      = (elem_q != 3'd0) && !phase_q;
      down         = (elem_q == 3'd3) || (elem_q == 3'd4);
      invert       = ((elem_q == 3'd1) || (elem_q == 3'd3)) ? phase_q :
                     ((elem_q == 3'd2) || (elem_q == 3'd4)) ? !phase_q : 1'b0;
      op_addr      = down ? ~addr_q : addr_q;
      op_data      = invert ? ~bg_pattern(bg_q) : bg_pattern(bg_q);
      last_in_addr = !two_op || phase_q;
      elem_end     = last_in_addr && (&addr_q);
      mismatch     = rd_vld_q && (bus.mem_rdata != exp_q);
   end

   always_comb begin
      // NOTE: every next-state signal gets its hold value first so no path can infer a latch.
      state_d = state_q;
      bg_d    = bg_q;
      elem_d  = elem_q;
      addr_d  = addr_q;
      phase_d = phase_q;
      drain_d = drain_q;
      case (state_q)
         S_IDLE, S_DONE: begin
            if (start_ok) begin
               state_d = S_RUN;
               bg_d    = 2'd0;
               elem_d  = 3'd0;
               addr_d  = '0;
               phase_d = 1'b0;
            end
         end
         S_RUN: begin
            drain_d = 1'b0;
            if (!last_in_addr) begin
               phase_d = 1'b1;
            end else begin
               phase_d = 1'b0;
               addr_d  = addr_q + 1'b1;
            end
            if (elem_end) begin
               if (elem_q == 3'd5) begin
                  elem_d = 3'd0;
                  if (bg_q == LAST_BG) state_d = S_DRAIN;
                  else                 bg_d    = bg_q + 2'd1;
               end else begin
                  elem_d = elem_q + 3'd1;
               end
            end
            if (STOP_ON_FAIL && mismatch) state_d = S_DRAIN;
         end
         S_DRAIN: begin
            drain_d = 1'b1;
            if (drain_q) state_d = S_DONE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         bg_q    <= 2'd0;
         elem_q  <= 3'd0;
         addr_q  <= '0;
         phase_q <= 1'b0;
         drain_q <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every register samples the pre-edge values.
         state_q <= state_d;
         bg_q    <= bg_d;
         elem_q  <= elem_d;
         addr_q  <= addr_d;
         phase_q <= phase_d;
         drain_q <= drain_d;
      end
   end

   // Compare context travels with each read so it lines up with the returning data.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_vld_q   <= 1'b0;
         exp_q      <= '0;
         cmp_addr_q <= '0;
         cmp_bg_q   <= 2'd0;
         cmp_elem_q <= 3'd0;
      end else begin
         rd_vld_q <= run && is_read;
         if (run && is_read) begin
            exp_q      <= op_data;
            cmp_addr_q <= op_addr;
            cmp_bg_q   <= bg_q;
            cmp_elem_q <= elem_q;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fail_q       <= 1'b0;
         fail_addr_q  <= '0;
         fail_bg_q    <= 2'd0;
         fail_elem_q  <= 3'd0;
         fail_exp_q   <= '0;
         fail_act_q   <= '0;
         fail_count_q <= '0;
      end else if (start_ok) begin
         fail_q       <= 1'b0;
         fail_addr_q  <= '0;
         fail_bg_q    <= 2'd0;
         fail_elem_q  <= 3'd0;
         fail_exp_q   <= '0;
         fail_act_q   <= '0;
         fail_count_q <= '0;
      end else if (mismatch) begin
         fail_q <= 1'b1;
         if (!fail_q) begin
            fail_addr_q <= cmp_addr_q;
            fail_bg_q   <= cmp_bg_q;
            fail_elem_q <= cmp_elem_q;
            fail_exp_q  <= exp_q;
            fail_act_q  <= bus.mem_rdata;
         end
         if (!(&fail_count_q)) fail_count_q <= fail_count_q + 1'b1;
      end
   end

   assign bus.bist_busy     = run || (state_q == S_DRAIN);
   assign bus.bist_done     = (state_q == S_DONE);
   assign bus.bist_fail     = fail_q;
   assign bus.mem_en        = run;
   assign bus.mem_we        = run && !is_read;
   assign bus.mem_addr      = run ? op_addr : '0;
   assign bus.mem_wdata     = (run && !is_read) ? op_data : '0;
   assign bus.fail_addr     = fail_addr_q;
   assign bus.fail_bg       = fail_bg_q;
   assign bus.fail_elem     = fail_elem_q;
   assign bus.fail_expected = fail_exp_q;
   assign bus.fail_actual   = fail_act_q;
   assign bus.fail_count    = fail_count_q;

endmodule

// File: tb/tb_march_bist_ctrl.sv
// Directed bench for march_bist_ctrl: four configurations, each with its own SRAM model.
// A selector routes one instance to the shared run task and observation signals.
module tb_march_bist_ctrl;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   logic [1:0] sel       = 2'd0;
   logic       start_req = 1'b0;
   logic       fault_c   = 1'b1;

   // a: 4x8 one background; b: 16x32 four backgrounds; c/d: 16x8 with a stuck-at cell.
   march_bist_ctrl_if #(.ADDR_W(2), .DATA_W(8),  .CNT_W(16)) if_a ();
   march_bist_ctrl_if #(.ADDR_W(4), .DATA_W(32), .CNT_W(16)) if_b ();
   march_bist_ctrl_if #(.ADDR_W(4), .DATA_W(8),  .CNT_W(16)) if_c ();
   march_bist_ctrl_if #(.ADDR_W(4), .DATA_W(8),  .CNT_W(16)) if_d ();

   march_bist_ctrl #(.ADDR_W(2), .DATA_W(8),  .NUM_BG(1), .CNT_W(16), .STOP_ON_FAIL(1'b0))
      u_a (.clk(clk), .rst(rst), .bus(if_a));
   march_bist_ctrl #(.ADDR_W(4), .DATA_W(32), .NUM_BG(4), .CNT_W(16), .STOP_ON_FAIL(1'b0))
      u_b (.clk(clk), .rst(rst), .bus(if_b));
   march_bist_ctrl #(.ADDR_W(4), .DATA_W(8),  .NUM_BG(1), .CNT_W(16), .STOP_ON_FAIL(1'b0))
      u_c (.clk(clk), .rst(rst), .bus(if_c));
   march_bist_ctrl #(.ADDR_W(4), .DATA_W(8),  .NUM_BG(1), .CNT_W(16), .STOP_ON_FAIL(1'b1))
      u_d (.clk(clk), .rst(rst), .bus(if_d));

   assign if_a.bist_start = start_req && (sel == 2'd0);
   assign if_b.bist_start = start_req && (sel == 2'd1);
   assign if_c.bist_start = start_req && (sel == 2'd2);
   assign if_d.bist_start = start_req && (sel == 2'd3);

   logic [7:0]  mem_a [4];
   logic [31:0] mem_b [16];
   logic [7:0]  mem_c [16];
   logic [7:0]  mem_d [16];

   always @(posedge clk) if (if_a.mem_en) begin
      if (if_a.mem_we) mem_a[if_a.mem_addr] <= if_a.mem_wdata;
      else             if_a.mem_rdata <= mem_a[if_a.mem_addr];
   end
   always @(posedge clk) if (if_b.mem_en) begin
      if (if_b.mem_we) mem_b[if_b.mem_addr] <= if_b.mem_wdata;
      else             if_b.mem_rdata <= mem_b[if_b.mem_addr];
   end
   // Bit 0 of word 5 stuck at 1 (modelled on the read side).
   always @(posedge clk) if (if_c.mem_en) begin
      if (if_c.mem_we) mem_c[if_c.mem_addr] <= if_c.mem_wdata;
      else if_c.mem_rdata <= mem_c[if_c.mem_addr] |
                             ((fault_c && if_c.mem_addr == 4'd5) ? 8'h01 : 8'h00);
   end
   always @(posedge clk) if (if_d.mem_en) begin
      if (if_d.mem_we) mem_d[if_d.mem_addr] <= if_d.mem_wdata;
      else if_d.mem_rdata <= mem_d[if_d.mem_addr] | ((if_d.mem_addr == 4'd5) ? 8'h01 : 8'h00);
   end

   logic        o_en, o_we, o_busy, o_done, o_fail;
   logic [31:0] o_addr, o_wdata, o_cnt, o_faddr, o_fexp, o_fact;
   logic [1:0]  o_fbg;
   logic [2:0]  o_felem;

   always_comb begin
      o_en = 1'b0; o_we = 1'b0; o_busy = 1'b0; o_done = 1'b0; o_fail = 1'b0;
      o_addr = '0; o_wdata = '0; o_cnt = '0; o_faddr = '0; o_fexp = '0; o_fact = '0;
      o_fbg = '0; o_felem = '0;
      case (sel)
         2'd0: begin
            o_en = if_a.mem_en; o_we = if_a.mem_we; o_busy = if_a.bist_busy;
            o_done = if_a.bist_done; o_fail = if_a.bist_fail;
            o_addr = 32'(if_a.mem_addr); o_wdata = 32'(if_a.mem_wdata);
            o_cnt = 32'(if_a.fail_count); o_faddr = 32'(if_a.fail_addr);
            o_fexp = 32'(if_a.fail_expected); o_fact = 32'(if_a.fail_actual);
            o_fbg = if_a.fail_bg; o_felem = if_a.fail_elem;
         end
         2'd1: begin
            o_en = if_b.mem_en; o_we = if_b.mem_we; o_busy = if_b.bist_busy;
            o_done = if_b.bist_done; o_fail = if_b.bist_fail;
            o_addr = 32'(if_b.mem_addr); o_wdata = if_b.mem_wdata;
            o_cnt = 32'(if_b.fail_count); o_faddr = 32'(if_b.fail_addr);
            o_fexp = if_b.fail_expected; o_fact = if_b.fail_actual;
            o_fbg = if_b.fail_bg; o_felem = if_b.fail_elem;
         end
         2'd2: begin
            o_en = if_c.mem_en; o_we = if_c.mem_we; o_busy = if_c.bist_busy;
            o_done = if_c.bist_done; o_fail = if_c.bist_fail;
            o_addr = 32'(if_c.mem_addr); o_wdata = 32'(if_c.mem_wdata);
            o_cnt = 32'(if_c.fail_count); o_faddr = 32'(if_c.fail_addr);
            o_fexp = 32'(if_c.fail_expected); o_fact = 32'(if_c.fail_actual);
            o_fbg = if_c.fail_bg; o_felem = if_c.fail_elem;
         end
         default: begin
            o_en = if_d.mem_en; o_we = if_d.mem_we; o_busy = if_d.bist_busy;
            o_done = if_d.bist_done; o_fail = if_d.bist_fail;
            o_addr = 32'(if_d.mem_addr); o_wdata = 32'(if_d.mem_wdata);
            o_cnt = 32'(if_d.fail_count); o_faddr = 32'(if_d.fail_addr);
            o_fexp = 32'(if_d.fail_expected); o_fact = 32'(if_d.fail_actual);
            o_fbg = if_d.fail_bg; o_felem = if_d.fail_elem;
         end
      endcase
   end

   logic        q_we   [$];
   logic [31:0] q_addr [$];
   logic [31:0] q_data [$];
   logic        first_fail, first_done;
   logic [31:0] first_cnt;

   // Pulses start, logs every issued op, returns the edge count (after the start edge)
   // at which bist_done is first seen, or -1 if the budget runs out first.
   task automatic run_bist(input int lim, input int p1, input int p2, output int done_cyc);
      int cyc;
      q_we.delete(); q_addr.delete(); q_data.delete();
      @(negedge clk); start_req = 1'b1;
      @(posedge clk);
      @(negedge clk); start_req = 1'b0;
      first_fail = o_fail; first_done = o_done; first_cnt = o_cnt;
      cyc = 0;
      while (!o_done && cyc < lim) begin
         if (o_en) begin q_we.push_back(o_we); q_addr.push_back(o_addr); q_data.push_back(o_wdata); end
         @(posedge clk); cyc++;
         @(negedge clk);
         start_req = (cyc == p1) || (cyc == p2);
      end
      start_req = 1'b0;
      done_cyc = o_done ? cyc : -1;
   endtask

   task automatic test_reset();
      for (int s = 0; s < 4; s++) begin
         sel = 2'(s); #1;
         total++;
         if ({o_en, o_we, o_busy, o_done, o_fail, o_addr, o_wdata, o_cnt, o_faddr, o_fexp, o_fact, o_fbg, o_felem} !== '0)
            begin bad++; $display("FAIL reset_outputs inst=%0d: en=%b busy=%b done=%b fail=%b cnt=%0d, want all 0", s, o_en, o_busy, o_done, o_fail, o_cnt); end
      end
      @(negedge clk); rst = 1'b0;
   endtask

   task automatic test_small_fault_free();
      int dc;
      sel = 2'd0;
      run_bist(1000, -1, -1, dc);
      total++; if (dc !== 42) begin bad++; $display("FAIL small_done_cycle: got %0d want 42", dc); end
      total++; if (q_we.size() !== 40) begin bad++; $display("FAIL small_op_count: got %0d want 40", q_we.size()); end
      total++; if (o_fail !== 1'b0 || o_cnt !== 32'd0) begin bad++; $display("FAIL small_fail: fail=%b cnt=%0d want 0/0", o_fail, o_cnt); end
      total++; if ({q_we[0], q_addr[0], q_data[0]} !== {1'b1, 32'd0, 32'h00})
         begin bad++; $display("FAIL small_first_write: we=%b addr=%0d data=%h want 1/0/00", q_we[0], q_addr[0], q_data[0]); end
      total++; if ({q_addr[20], q_addr[22], q_addr[24], q_addr[26]} !== {32'd3, 32'd2, 32'd1, 32'd0})
         begin bad++; $display("FAIL small_e3_addrs: got %0d,%0d,%0d,%0d want 3,2,1,0", q_addr[20], q_addr[22], q_addr[24], q_addr[26]); end
      total++; if ({q_we[20], q_we[21], q_data[21]} !== {1'b0, 1'b1, 32'hFF})
         begin bad++; $display("FAIL small_e3_ops: r_we=%b w_we=%b wdata=%h want 0/1/ff", q_we[20], q_we[21], q_data[21]); end
   endtask

   task automatic test_large_fault_free();
      int dc;
      sel = 2'd1;
      run_bist(2000, -1, -1, dc);
      total++; if (dc !== 642) begin bad++; $display("FAIL large_done_cycle: got %0d want 642", dc); end
      total++; if (o_fail !== 1'b0 || o_cnt !== 32'd0) begin bad++; $display("FAIL large_fail: fail=%b cnt=%0d want 0/0", o_fail, o_cnt); end
      total++; if ({q_we[160], q_addr[160], q_data[160]} !== {1'b1, 32'd0, 32'h55555555})
         begin bad++; $display("FAIL large_bg1_e0: we=%b addr=%0d data=%h want 1/0/55555555", q_we[160], q_addr[160], q_data[160]); end
      total++; if ({q_we[176], q_addr[176]} !== {1'b0, 32'd0})
         begin bad++; $display("FAIL large_bg1_e1_read: we=%b addr=%0d want 0/0", q_we[176], q_addr[176]); end
      total++; if ({q_we[177], q_addr[177], q_data[177]} !== {1'b1, 32'd0, 32'hAAAAAAAA})
         begin bad++; $display("FAIL large_bg1_e1_write: we=%b addr=%0d data=%h want 1/0/aaaaaaaa", q_we[177], q_addr[177], q_data[177]); end
      total++; if ({q_we[639], q_addr[639]} !== {1'b0, 32'd15})
         begin bad++; $display("FAIL large_last_op: we=%b addr=%0d want 0/15", q_we[639], q_addr[639]); end
   endtask

   task automatic test_fault_continue();
      int dc;
      sel = 2'd2; fault_c = 1'b1;
      run_bist(1000, -1, -1, dc);
      total++; if (dc !== 162) begin bad++; $display("FAIL cont_done_cycle: got %0d want 162", dc); end
      total++; if (o_fail !== 1'b1) begin bad++; $display("FAIL cont_fail_flag: got %b want 1", o_fail); end
      total++; if (o_felem !== 3'd1 || o_fbg !== 2'd0) begin bad++; $display("FAIL cont_elem_bg: elem=%0d bg=%0d want 1/0", o_felem, o_fbg); end
      total++; if (o_faddr !== 32'd5) begin bad++; $display("FAIL cont_addr: got %0d want 5", o_faddr); end
      total++; if (o_fexp !== 32'h00 || o_fact !== 32'h01) begin bad++; $display("FAIL cont_data: exp=%h act=%h want 00/01", o_fexp, o_fact); end
      total++; if (o_cnt !== 32'd3) begin bad++; $display("FAIL cont_count: got %0d want 3", o_cnt); end
   endtask

   task automatic test_fault_stop();
      int dc;
      sel = 2'd3;
      run_bist(1000, -1, -1, dc);
      total++; if (dc !== 30) begin bad++; $display("FAIL stop_done_cycle: got %0d want 30", dc); end
      total++; if (q_we.size() !== 28) begin bad++; $display("FAIL stop_op_count: got %0d want 28", q_we.size()); end
      total++; if (o_cnt !== 32'd1 || o_fail !== 1'b1) begin bad++; $display("FAIL stop_count: cnt=%0d fail=%b want 1/1", o_cnt, o_fail); end
      total++; if (o_faddr !== 32'd5 || o_felem !== 3'd1) begin bad++; $display("FAIL stop_diag: addr=%0d elem=%0d want 5/1", o_faddr, o_felem); end
   endtask

   task automatic test_restart_from_done();
      int dc;
      sel = 2'd2; fault_c = 1'b0;
      run_bist(1000, -1, -1, dc);
      total++; if ({first_fail, first_done, first_cnt} !== '0)
         begin bad++; $display("FAIL restart_clear: fail=%b done=%b cnt=%0d want 0/0/0", first_fail, first_done, first_cnt); end
      total++; if (dc !== 162) begin bad++; $display("FAIL restart_done_cycle: got %0d want 162", dc); end
      total++; if (o_fail !== 1'b0 || o_cnt !== 32'd0) begin bad++; $display("FAIL restart_result: fail=%b cnt=%0d want 0/0", o_fail, o_cnt); end
   endtask

   task automatic test_start_ignored();
      int dc;
      sel = 2'd0;
      run_bist(1000, 10, 40, dc);
      total++; if (dc !== 42) begin bad++; $display("FAIL ignore_done_cycle: got %0d want 42", dc); end
      total++; if (q_we.size() !== 40) begin bad++; $display("FAIL ignore_op_count: got %0d want 40", q_we.size()); end
   endtask

   task automatic test_reset_mid_run();
      int dc;
      sel = 2'd2; fault_c = 1'b1;
      run_bist(60, -1, -1, dc);
      total++; if (o_busy !== 1'b1 || o_fail !== 1'b1 || o_en !== 1'b1)
         begin bad++; $display("FAIL midrun_pre: busy=%b fail=%b en=%b want 1/1/1", o_busy, o_fail, o_en); end
      #1 rst = 1'b1;
      #1;
      total++; if ({o_en, o_we, o_busy, o_done, o_fail, o_addr, o_wdata, o_cnt, o_faddr, o_fexp, o_fact, o_fbg, o_felem} !== '0)
         begin bad++; $display("FAIL midrun_async_reset: en=%b busy=%b fail=%b cnt=%0d addr=%0d want all 0", o_en, o_busy, o_fail, o_cnt, o_faddr); end
      @(negedge clk); rst = 1'b0;
      fault_c = 1'b0;
      run_bist(1000, -1, -1, dc);
      total++; if (dc !== 162) begin bad++; $display("FAIL midrun_rerun_cycle: got %0d want 162", dc); end
      total++; if (o_fail !== 1'b0 || o_cnt !== 32'd0) begin bad++; $display("FAIL midrun_rerun_result: fail=%b cnt=%0d want 0/0", o_fail, o_cnt); end
   endtask

   initial begin
      #2;
      test_reset();
      test_small_fault_free();
      test_large_fault_free();
      test_fault_continue();
      test_fault_stop();
      test_restart_from_done();
      test_start_ignored();
      test_reset_mid_run();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/march_bist_ctrl.md
Name: march_bist_ctrl

Overview:
Parametrised March C- built-in self-test controller. It is the successor to the fixed-pattern SRAM BIST.
- Drives a single-port synchronous SRAM with 1-cycle read latency.
- Configurable address/data width and number of data backgrounds.
- Start/busy/done/fail handshake.
- Captures diagnostics for the first failing read and counts all mismatches.
- Sits between the top-level test controller and each SRAM macro wrapper.

Parameters:
ADDR_W, 4, SRAM address width; DEPTH = 2**ADDR_W words.
DATA_W, 32, SRAM data width; multiple of 8.
NUM_BG, 4, number of data backgrounds run, 1..4.
CNT_W, 16, width of the saturating mismatch counter.
STOP_ON_FAIL, 0, 1 = abort the run after the first mismatch.

Ports:
clk  in  1  clock; all state updates on the rising edge.
rst  in  1  asynchronous, active-high reset.
bist_start  in  1  single-cycle request; accepted only in IDLE or DONE.
bist_busy  out  1  high in RUN and DRAIN.
bist_done  out  1  high in DONE; held until the next accepted start or reset.
bist_fail  out  1  sticky; set on any mismatch; cleared on accepted start.
mem_en  out  1  SRAM access enable.
mem_we  out  1  1 = write, 0 = read; valid when mem_en = 1.
mem_addr  out  ADDR_W  SRAM address.
mem_wdata  out  DATA_W  SRAM write data.
mem_rdata  in  DATA_W  SRAM read data; valid the cycle after a read.
fail_addr  out  ADDR_W  address of the first mismatch.
fail_bg  out  2  background index of the first mismatch.
fail_elem  out  3  March element index (0..5) of the first mismatch.
fail_expected  out  DATA_W  expected data at the first mismatch.
fail_actual  out  DATA_W  read data at the first mismatch.
fail_count  out  CNT_W  number of mismatching reads; saturates at all-ones.

Behaviour:
- Reset (asynchronous, active-high rst):
  - All outputs go to 0 immediately; FSM goes to IDLE.
  - A reset mid-run aborts the run; mem_en drops in the same cycle.
- Backgrounds D[b], each byte replicated across DATA_W:
  - D0 = 8'h00, D1 = 8'h55, D2 = 8'h33, D3 = 8'h0F.
  - "0" in the algorithm denotes D[b]; "1" denotes ~D[b].
- March C- per background, with elements numbered 0..5:
  - e0 ⇑ (w0)
  - e1 ⇑ (r0, w1)
  - e2 ⇑ (r1, w0)
  - e3 ⇓ (r0, w1)
  - e4 ⇓ (r1, w0)
  - e5 ⇑ (r0)
  - ⇑ runs address 0..DEPTH-1; ⇓ runs DEPTH-1..0.
- Operation timing:
  - One SRAM operation per cycle, with no idle cycles between operations, addresses, elements or backgrounds.
  - Ops per background = 10*DEPTH; total OPS = 10*DEPTH*NUM_BG.
- FSM states: IDLE, RUN, DRAIN, DONE.
  - IDLE/DONE + bist_start → RUN. On acceptance: bist_fail, fail_* and fail_count clear, bist_done drops, b = 0, element = 0.
  - RUN: one op per cycle. After the last op of e5 of the last background → DRAIN.
  - DRAIN: lasts 2 cycles (read latency plus compare), mem_en = 0, then → DONE.
  - DONE: bist_done = 1, bist_busy = 0, all results held.
- Start timing:
  - The first op is driven in the cycle after the start edge.
  - bist_done is first seen high at the edge OPS+2 cycles after the edge that sampled bist_start.
  - bist_start is ignored in RUN and DRAIN.
- Compare pipeline:
  - Expected data, address, bg and element are registered alongside each read.
  - Compare happens the cycle rdata is valid; on mismatch the result is registered one cycle later.
  - fail_* load only on the first mismatch of a run.
  - fail_count increments per mismatching read and saturates.
- STOP_ON_FAIL = 1:
  - On detecting a mismatch, issue no further ops.
  - Go to DRAIN, then DONE; reads already in flight are still compared and counted.
- STOP_ON_FAIL = 0: the run always completes all OPS.
- Outside RUN, mem_en = 0, and mem_we/mem_addr/mem_wdata hold 0.

Test Plan:
- Fault-free model, ADDR_W = 2, DATA_W = 8, NUM_BG = 1 → done at OPS+2 = 42 cycles after start; fail = 0; fail_count = 0; first write addr 0 data 8'h00; e3 addresses 3,2,1,0.
- Fault-free model, ADDR_W = 4, DATA_W = 32, NUM_BG = 4 → done at 642 cycles; e1 of bg1 reads expect 32'h55555555 and write 32'hAAAAAAAA.
- Bit0 stuck-at-1 at addr 5, ADDR_W = 4, DATA_W = 8, NUM_BG = 1, STOP_ON_FAIL = 0 → first fail: fail_elem = 1, fail_addr = 5, fail_expected = 8'h00, fail_actual = 8'h01, fail_bg = 0; fail_count = 3 (e1, e3, e5 r0); done at 162 cycles.
- Same fault with STOP_ON_FAIL = 1 → bist_done within 4 cycles of the e1 read of addr 5; no ops issued after detection; fail_count = 1.
- rst asserted mid e2 → all outputs 0 asynchronously. New start then gives a clean full run with fail = 0.
- bist_start pulsed during RUN is ignored. Restart from DONE clears bist_fail and fail_count and reruns with identical timing.
